// File: rtl/booth_operand_sequencer_pkg.sv
// Shared constants for the Booth operand sequencer: default widths, timing
// parameters and the 3-bit FSM state encoding.
package booth_operand_sequencer_pkg;

  localparam int P_N         = 16;
  localparam int P_TAG_W     = 4;
  localparam int P_DEPTH     = 4;
  localparam int P_TIMEOUT   = 64;
  localparam int P_REARM_CYC = 2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_START = 3'd1;
  localparam state_t S_LD_M  = 3'd2;
  localparam state_t S_LD_Q  = 3'd3;
  localparam state_t S_WAIT  = 3'd4;
  localparam state_t S_REARM = 3'd5;

endpackage

// File: rtl/booth_operand_sequencer_fifo.sv
// Small synchronous FIFO holding {tag, mplier, mcand} operand records.
// Pushes at full and pops at empty are dropped; pointers wrap modulo DEPTH.
module booth_op_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == CW'(0));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage write and pointer/occupancy bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/booth_operand_sequencer.sv
// Feeds queued operand pairs into the Booth multiplier core: start pulse,
// M then Q on the shared data bus, wait for done (or time out), pulse rearm
// and report the job's tag. All handshake outputs are registered.
module booth_operand_sequencer
  import booth_operand_sequencer_pkg::*;
#(
  parameter int N         = P_N,
  parameter int TAG_W     = P_TAG_W,
  parameter int DEPTH     = P_DEPTH,
  parameter int TIMEOUT   = P_TIMEOUT,
  parameter int REARM_CYC = P_REARM_CYC
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [N-1:0]               i_in_mcand,
  input  logic [N-1:0]               i_in_mplier,
  input  logic [TAG_W-1:0]           i_in_tag,
  output logic                       o_start,
  output logic [N-1:0]               o_data_in,
  input  logic                       i_done,
  output logic                       o_rearm,
  output logic                       o_job_valid,
  output logic [TAG_W-1:0]           o_job_tag,
  output logic                       o_job_timeout,
  output logic                       o_busy,
  output logic [$clog2(DEPTH+1)-1:0] o_fifo_count
);

  localparam int FW = 2 * N + TAG_W;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (REARM_CYC > 1) ? $clog2(REARM_CYC) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_timeout_nxt;
  logic             w_rearm_entry;
  logic [TW-1:0]    r_timer;
  logic [RW-1:0]    r_rearm_cnt;
  logic [TAG_W-1:0] r_cur_tag;

  logic [FW-1:0]    w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [N-1:0]     w_head_mcand;
  logic [N-1:0]     w_head_mplier;
  logic [TAG_W-1:0] w_head_tag;

  // Head entry is consumed at the edge leaving LD_Q, after both operands went out.
  assign w_pop         = (r_state == S_LD_Q);
  assign o_in_ready    = !w_full;
  assign w_head_mcand  = w_head[N-1:0];
  assign w_head_mplier = w_head[2*N-1:N];
  assign w_head_tag    = w_head[FW-1:2*N];
  assign w_rearm_entry = (r_state == S_WAIT) && (w_state_nxt == S_REARM);

  booth_op_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_in_valid),
    .i_wdata ({i_in_tag, i_in_mplier, i_in_mcand}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_fifo_count)
  );

  // Next-state decode; done only matters in WAIT and beats a same-cycle timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE:  begin
        if (!w_empty) w_state_nxt = S_START;
        else          w_state_nxt = S_IDLE;
      end
      S_START: w_state_nxt = S_LD_M;
      S_LD_M:  w_state_nxt = S_LD_Q;
      S_LD_Q:  w_state_nxt = S_WAIT;
      S_WAIT:  begin
        if (i_done) begin
          w_state_nxt   = S_REARM;
          w_timeout_nxt = 1'b0;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_state_nxt   = S_REARM;
          w_timeout_nxt = 1'b1;
        end else begin
          w_state_nxt   = S_WAIT;
        end
      end
      S_REARM: begin
        if (r_rearm_cnt == RW'(REARM_CYC - 1)) w_state_nxt = S_IDLE;
        else                                   w_state_nxt = S_REARM;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, timers, tag capture and registered Moore outputs (decoded from next state).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_rearm_cnt   <= '0;
      r_cur_tag     <= '0;
      o_start       <= 1'b0;
      o_data_in     <= '0;
      o_rearm       <= 1'b0;
      o_job_valid   <= 1'b0;
      o_job_tag     <= '0;
      o_job_timeout <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_WAIT) r_timer <= r_timer + TW'(1);
      else                   r_timer <= '0;

      if (r_state == S_REARM) r_rearm_cnt <= r_rearm_cnt + RW'(1);
      else                    r_rearm_cnt <= '0;

      if (r_state == S_LD_Q) r_cur_tag <= w_head_tag;

      o_start       <= (w_state_nxt == S_START);
      o_busy        <= (w_state_nxt != S_IDLE);
      o_rearm       <= w_rearm_entry;
      o_job_valid   <= w_rearm_entry;
      o_job_timeout <= w_rearm_entry ? w_timeout_nxt : 1'b0;
      if (w_rearm_entry) o_job_tag <= r_cur_tag;

      case (w_state_nxt)
        S_LD_M:  o_data_in <= w_head_mcand;
        S_LD_Q:  o_data_in <= w_head_mplier;
        default: o_data_in <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Scoreboard bench: pushes record expected jobs; a core model checks the load
// sequence and drives done; a monitor checks every job_valid against the queue.
module tb_booth_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mcand;
  logic [15:0] in_mplier;
  logic [3:0]  in_tag;
  logic        start;
  logic [15:0] data_in;
  logic        done;
  logic        core_done;
  logic        spur_done;
  logic        rearm;
  logic        job_valid;
  logic [3:0]  job_tag;
  logic        job_timeout;
  logic        busy;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [15:0] mcand; logic [15:0] mplier; int d; bit spur; } op_s;
  typedef struct { logic [3:0] tag; bit to; } job_s;
  op_s  op_q[$];
  job_s exp_q[$];
  job_s mon_e;

  assign done = core_done | spur_done;

  always #5 clk = ~clk;

  booth_operand_sequencer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_mcand    (in_mcand),
    .i_in_mplier   (in_mplier),
    .i_in_tag      (in_tag),
    .o_start       (start),
    .o_data_in     (data_in),
    .i_done        (done),
    .o_rearm       (rearm),
    .o_job_valid   (job_valid),
    .o_job_tag     (job_tag),
    .o_job_timeout (job_timeout),
    .o_busy        (busy),
    .o_fifo_count  (fifo_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] mc, input logic [15:0] mp, input logic [3:0] tg,
                      input int d, input bit to, input bit expect_job, input bit spur);
    int cnt;
    op_s  o;
    job_s j;
    @(negedge clk);
    in_valid  = 1'b1;
    in_mcand  = mc;
    in_mplier = mp;
    in_tag    = tg;
    cnt = 0;
    while (!in_ready && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 1000) begin
      checks++;
      errors++;
      $display("FAIL push_ready_wait tag=%0d ready=%0b expected=1", tg, in_ready);
    end
    @(posedge clk);
    o.mcand = mc; o.mplier = mp; o.d = d; o.spur = spur;
    op_q.push_back(o);
    if (expect_job) begin
      j.tag = tg; j.to = to;
      exp_q.push_back(j);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int cnt = 0;
    while ((exp_q.size() != 0 || op_q.size() != 0 || busy) && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_wait pending=%0d busy=%0b expected pending=0", exp_q.size(), busy);
    end
  endtask

  // Core model: checks start/M/Q/0 sequence, raises done d cycles after start, checks rearm timing.
  initial begin
    op_s op;
    int  n;
    bit  aborted;
    core_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && start) begin
        chk("op_available", 32'(op_q.size() != 0), 32'd1);
        if (op_q.size() != 0) begin
          op = op_q.pop_front();
          @(negedge clk);
          chk("start_one_cycle", 32'(start), 32'd0);
          chk("data_in_mcand", 32'(data_in), 32'(op.mcand));
          if (op.spur) core_done = 1'b1;
          @(negedge clk);
          core_done = 1'b0;
          chk("data_in_mplier", 32'(data_in), 32'(op.mplier));
          @(negedge clk);
          chk("data_in_wait_zero", 32'(data_in), 32'd0);
          n = 0;
          aborted = 1'b0;
          while (1) begin
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if (rearm) break;
            if (n > 300) begin
              checks++;
              errors++;
              $display("FAIL rearm_wait cycles=%0d expected<=64", n);
              aborted = 1'b1;
              break;
            end
            if (op.d != 0 && n + 3 == op.d) core_done = 1'b1;
            @(negedge clk);
            n++;
          end
          core_done = 1'b0;
          if (!aborted) begin
            chk("rearm_latency", 32'(n), (op.d == 0) ? 32'd64 : 32'(op.d - 2));
            chk("job_valid_with_rearm", 32'(job_valid), 32'd1);
          end
        end
      end
    end
  end

  // Monitor: every job_valid pulse must match the oldest expected job.
  always @(negedge clk) begin
    if (!rst && job_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_job tag=%0d timeout=%0b expected none", job_tag, job_timeout);
      end else begin
        mon_e = exp_q.pop_front();
        chk("job_tag", 32'(job_tag), 32'(mon_e.tag));
        chk("job_timeout", 32'(job_timeout), 32'(mon_e.to));
      end
    end
  end

  initial begin
    int cnt;
    rst = 1'b1; in_valid = 1'b0; in_mcand = '0; in_mplier = '0; in_tag = '0; spur_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_rearm", 32'(rearm), 32'd0);
    chk("rst_job_valid", 32'(job_valid), 32'd0);
    chk("rst_job_timeout", 32'(job_timeout), 32'd0);
    chk("rst_job_tag", 32'(job_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    @(posedge clk); #3 rst = 1'b0;

    // 1: single job, start two cycles after acceptance
    push(16'd7, 16'hFFFD, 4'd3, 34, 1'b0, 1'b1, 1'b0);
    idle();
    chk("t1_idle_start", 32'(start), 32'd0);
    chk("t1_count", 32'(fifo_count), 32'd1);
    @(negedge clk);
    chk("t1_start", 32'(start), 32'd1);
    wait_done();

    // 2: fill the FIFO, fifth push waits for the first pop
    for (int t = 0; t < 4; t++) push(16'(100 + t), 16'(200 + t), 4'(t), 10, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_full_count", 32'(fifo_count), 32'd4);
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    push(16'd104, 16'd204, 4'd4, 10, 1'b0, 1'b1, 1'b0);
    idle();
    chk("t2_after_pop_count", 32'(fifo_count), 32'd4);
    wait_done();

    // 3: timeout, then a normal job
    push(16'h1111, 16'h2222, 4'd5, 0, 1'b1, 1'b1, 1'b0);
    push(16'h3333, 16'h4444, 4'd6, 12, 1'b0, 1'b1, 1'b0);
    idle();
    wait_done();

    // 4: done on the last timer cycle wins
    push(16'hABCD, 16'h0102, 4'd7, 66, 1'b0, 1'b1, 1'b0);
    idle();
    wait_done();

    // 6: spurious done in IDLE and LD_M
    @(negedge clk);
    spur_done = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_idle_busy", 32'(busy), 32'd0);
      chk("t6_idle_start", 32'(start), 32'd0);
    end
    spur_done = 1'b0;
    push(16'h8000, 16'h1234, 4'd9, 20, 1'b0, 1'b1, 1'b1);
    idle();
    wait_done();

    // 5: reset while waiting, with a second job queued
    push(16'h5555, 16'h6666, 4'd10, 0, 1'b1, 1'b0, 1'b0);
    push(16'h7777, 16'h8888, 4'd11, 0, 1'b1, 1'b0, 1'b0);
    idle();
    cnt = 0;
    while (!start && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("t5_job_started", 32'(start), 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("t5_rst_start", 32'(start), 32'd0);
    chk("t5_rst_rearm", 32'(rearm), 32'd0);
    chk("t5_rst_job_valid", 32'(job_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_count", 32'(fifo_count), 32'd0);
    op_q.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_post_count", 32'(fifo_count), 32'd0);
    chk("t5_post_busy", 32'(busy), 32'd0);
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
